// File: rtl/sprite_rom_arbiter_if.sv
// Shared-ROM lookup bus: requester handshake, ROM address/data and per-requester responses.
// The slave modport is the arbiter side; the master modport is the requester/ROM side.
interface sprite_rom_arbiter_if #(
   parameter int NUM_REQ    = 3,
   parameter int ADDR_WIDTH = 19
);
   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
   logic [NUM_REQ-1:0]            req_ready;
   logic [ADDR_WIDTH-1:0]         rom_addr;
   logic                          rom_data;
   logic [NUM_REQ-1:0]            rsp_valid;
   logic [NUM_REQ-1:0]            rsp_data;
   logic                          err_oob;

   modport slave (
      input  req_valid, req_addr, rom_data,
      output req_ready, rom_addr, rsp_valid, rsp_data, err_oob
   );

   modport master (
      output req_valid, req_addr, rom_data,
      input  req_ready, rom_addr, rsp_valid, rsp_data, err_oob
   );
endinterface

// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one synchronous 1-bit sprite ROM among NUM_REQ requesters.
// One lookup per cycle, fixed two-edge latency from accept to the routed response.
module sprite_rom_arbiter #(
   parameter int NUM_REQ    = 3,
   parameter int ADDR_WIDTH = 19,
   parameter int ROM_DEPTH  = 235000
) (
   input  logic                  clk,
   input  logic                  reset,
   sprite_rom_arbiter_if.slave   bus
);

   localparam int                PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [PTR_W:0]    NUM_L  = (PTR_W+1)'(NUM_REQ);
   localparam logic [PTR_W-1:0]  LAST_L = PTR_W'(NUM_REQ - 1);
   localparam logic [63:0]       DEPTH_L = 64'(ROM_DEPTH);

   logic [PTR_W-1:0]        r_ptr;
   logic [2*NUM_REQ-1:0]    w_dbl;
   logic [NUM_REQ-1:0]      w_rot;
   logic [PTR_W-1:0]        w_off;
   logic [PTR_W:0]          w_sum;
   logic [PTR_W-1:0]        w_gnt;
   logic                    w_any;
   logic [ADDR_WIDTH-1:0]   w_addr;
   logic                    w_oob;

   logic [ADDR_WIDTH-1:0]   r_rom_addr;
   logic                    r_vld_p1;
   logic [PTR_W-1:0]        r_idx_p1;
   logic                    r_oob_p1;
   logic                    r_vld_p2;
   logic [PTR_W-1:0]        r_idx_p2;
   logic                    r_oob_p2;
   logic [NUM_REQ-1:0]      r_rsp_valid;
   logic [NUM_REQ-1:0]      r_rsp_data;
   logic                    r_err_oob;

   // Rotate valids so the pointer sits at bit 0, take the lowest set bit, then rotate back.
   always_comb begin
      w_dbl = {bus.req_valid, bus.req_valid} >> r_ptr;
      w_rot = w_dbl[NUM_REQ-1:0];
      w_any = |w_rot;
      w_off = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (w_rot[k]) w_off = PTR_W'(k);
      end
      w_sum = {1'b0, r_ptr} + {1'b0, w_off};
      if (w_sum >= NUM_L) w_sum = w_sum - NUM_L;
      w_gnt = w_sum[PTR_W-1:0];

      bus.req_ready = '0;
      if (w_any) bus.req_ready[w_gnt] = 1'b1;

      w_addr = bus.req_addr[w_gnt*ADDR_WIDTH +: ADDR_WIDTH];
      w_oob  = {{(64-ADDR_WIDTH){1'b0}}, w_addr} >= DEPTH_L;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_ptr       <= '0;
         r_rom_addr  <= '0;
         r_vld_p1    <= 1'b0;
         r_idx_p1    <= '0;
         r_oob_p1    <= 1'b0;
         r_vld_p2    <= 1'b0;
         r_idx_p2    <= '0;
         r_oob_p2    <= 1'b0;
         r_rsp_valid <= '0;
         r_rsp_data  <= '0;
         r_err_oob   <= 1'b0;
      end else begin
         // p1: accept edge, address launched to the ROM
         r_vld_p1 <= w_any;
         r_idx_p1 <= w_gnt;
         r_oob_p1 <= w_oob;
         if (w_any) begin
            r_ptr      <= (w_gnt == LAST_L) ? '0 : w_gnt + 1'b1;
            r_rom_addr <= w_oob ? '0 : w_addr;
            if (w_oob) r_err_oob <= 1'b1;
         end

         // p2: ROM is registering its output for the p1 address
         r_vld_p2 <= r_vld_p1;
         r_idx_p2 <= r_idx_p1;
         r_oob_p2 <= r_oob_p1;

         // output: capture the pixel for the originating requester only
         r_rsp_valid <= '0;
         if (r_vld_p2) begin
            r_rsp_valid[r_idx_p2] <= 1'b1;
            r_rsp_data[r_idx_p2]  <= bus.rom_data & ~r_oob_p2;
         end
      end
   end

   assign bus.rom_addr  = r_rom_addr;
   assign bus.rsp_valid = r_rsp_valid;
   assign bus.rsp_data  = r_rsp_data;
   assign bus.err_oob   = r_err_oob;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Bench for sprite_rom_arbiter: grant-table vectors, hand-written corner sequences and a
// randomized run against a queue-based reference model with a behavioural synchronous ROM.
module tb_sprite_rom_arbiter;

   localparam int N     = 3;
   localparam int AW    = 19;
   localparam int DEPTH = 235000;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   sprite_rom_arbiter_if #(.NUM_REQ(N), .ADDR_WIDTH(AW)) bus ();

   sprite_rom_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .ROM_DEPTH(DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // ROM contents: words 0 and 2500 are 1, others a scrambled parity
   function automatic logic rom_bit(input logic [AW-1:0] a);
      logic [31:0] t;
      if (a == 0 || a == 2500) return 1'b1;
      t = 32'(a) * 32'd13 + 32'd7;
      return ^t[7:0];
   endfunction

   always @(posedge clk) bus.rom_data <= rom_bit(bus.rom_addr);

   int checks = 0;
   int passes = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   logic [AW-1:0] a_cur [N];

   task automatic drive(input logic [N-1:0] v);
      bus.req_valid = v;
      for (int i = 0; i < N; i++) bus.req_addr[i*AW +: AW] = a_cur[i];
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < N; i++) a_cur[i] = '0;
      drive('0);
      @(negedge clk);
      chk("rst_rom_addr", bus.rom_addr, 0);
      chk("rst_rsp_valid", bus.rsp_valid, 0);
      chk("rst_rsp_data", bus.rsp_data, 0);
      chk("rst_err_oob", bus.err_oob, 0);
      @(negedge clk);
      reset = 1'b1;
   endtask

   // Reference: first valid requester found searching p, p+1, ... mod N
   function automatic int pick(input logic [N-1:0] v, input int p);
      for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
      return -1;
   endfunction

   function automatic logic [AW-1:0] rnd_addr();
      int r;
      r = $urandom_range(0, 9);
      if (r == 0) return AW'(DEPTH);
      if (r == 1) return AW'(DEPTH - 1);
      if (r == 2) return AW'($urandom_range(DEPTH, (1 << AW) - 1));
      return AW'($urandom_range(0, DEPTH - 1));
   endfunction

   typedef struct {
      logic [N-1:0]  v;
      logic [N-1:0]  exp_ready;
      logic [AW-1:0] exp_rom;
   } vec_t;

   typedef struct {
      int   due;
      int   g;
      logic b;
   } rsp_t;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t          tbl [10];
      rsp_t          pend [$];
      int            m_ptr, cyc, g;
      logic [AW-1:0] m_rom;
      logic [N-1:0]  m_rv, m_rd, v, last_ready, exp_ready;
      logic          m_err, oob;

      // requester i in row e presents address 10*e + i
      tbl[0] = '{3'b110, 3'b010, 19'd1};
      tbl[1] = '{3'b110, 3'b100, 19'd12};
      tbl[2] = '{3'b110, 3'b010, 19'd21};
      tbl[3] = '{3'b000, 3'b000, 19'd21};
      tbl[4] = '{3'b001, 3'b001, 19'd40};
      tbl[5] = '{3'b101, 3'b100, 19'd52};
      tbl[6] = '{3'b111, 3'b001, 19'd60};
      tbl[7] = '{3'b011, 3'b010, 19'd71};
      tbl[8] = '{3'b011, 3'b001, 19'd80};
      tbl[9] = '{3'b010, 3'b010, 19'd91};

      bus.req_valid = '0;
      bus.req_addr  = '0;
      do_reset();

      // Grant-order table from p=0
      for (int e = 0; e < 10; e++) begin
         @(negedge clk);
         if (e > 0) chk("tbl_rom_addr", bus.rom_addr, tbl[e-1].exp_rom);
         for (int i = 0; i < N; i++) a_cur[i] = AW'(10 * e + i);
         drive(tbl[e].v);
         #1 chk("tbl_ready", bus.req_ready, tbl[e].exp_ready);
      end
      @(negedge clk);
      chk("tbl_rom_addr", bus.rom_addr, tbl[9].exp_rom);
      drive('0);

      // Single lookup, two-edge latency
      do_reset();
      @(negedge clk);
      a_cur[0] = 19'd2500;
      drive(3'b001);
      #1 chk("single_ready", bus.req_ready, 3'b001);
      @(negedge clk);
      chk("single_rom_addr", bus.rom_addr, 2500);
      chk("single_no_early_rsp", bus.rsp_valid, 0);
      drive('0);
      @(negedge clk);
      chk("single_no_early_rsp2", bus.rsp_valid, 0);
      @(negedge clk);
      chk("single_rsp_valid", bus.rsp_valid, 3'b001);
      chk("single_rsp_data", bus.rsp_data, 3'b001);
      @(negedge clk);
      chk("single_pulse_end", bus.rsp_valid, 0);
      chk("single_data_hold", bus.rsp_data, 3'b001);

      // Out-of-range address after an in-range one on the same requester
      do_reset();
      @(negedge clk);
      a_cur[1] = 19'd2500;
      drive(3'b010);
      #1 chk("oob_ready0", bus.req_ready, 3'b010);
      @(negedge clk);
      chk("oob_rom_addr0", bus.rom_addr, 2500);
      chk("oob_err_clear", bus.err_oob, 0);
      a_cur[1] = AW'(DEPTH);
      drive(3'b010);
      #1 chk("oob_ready1", bus.req_ready, 3'b010);
      @(negedge clk);
      chk("oob_rom_addr_zero", bus.rom_addr, 0);
      chk("oob_err_set", bus.err_oob, 1);
      drive('0);
      @(negedge clk);
      chk("oob_first_rsp_valid", bus.rsp_valid, 3'b010);
      chk("oob_first_rsp_data", bus.rsp_data, 3'b010);
      @(negedge clk);
      chk("oob_rsp_valid", bus.rsp_valid, 3'b010);
      chk("oob_rsp_data_forced", bus.rsp_data, 3'b000);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("oob_err_sticky", bus.err_oob, 1);
         chk("oob_quiet", bus.rsp_valid, 0);
      end

      // Reset while lookups are in flight
      do_reset();
      @(negedge clk);
      a_cur[2] = 19'd2500;
      drive(3'b100);
      #1 chk("mid_ready", bus.req_ready, 3'b100);
      @(negedge clk);
      a_cur[0] = 19'd0;
      drive(3'b001);
      @(negedge clk);
      reset = 1'b0;
      drive('0);
      #1;
      chk("mid_rom_addr", bus.rom_addr, 0);
      chk("mid_rsp_valid", bus.rsp_valid, 0);
      chk("mid_rsp_data", bus.rsp_data, 0);
      @(negedge clk);
      reset = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("mid_no_rsp", bus.rsp_valid, 0);
         chk("mid_data_zero", bus.rsp_data, 0);
      end
      for (int i = 0; i < N; i++) a_cur[i] = AW'(300 + i);
      drive(3'b111);
      #1 chk("mid_first_grant", bus.req_ready, 3'b001);
      @(negedge clk);
      chk("mid_first_addr", bus.rom_addr, 300);
      drive('0);

      // All requesters held valid: strict rotation and one response each per three cycles
      do_reset();
      for (int i = 0; i < N; i++) a_cur[i] = AW'(100 + i);
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (c >= 3) begin
            chk("rr_rsp_valid", bus.rsp_valid, 3'b001 << ((c - 3) % 3));
            chk("rr_rsp_bit", bus.rsp_data[(c - 3) % 3], rom_bit(AW'(100 + (c - 3) % 3)));
         end
         drive(3'b111);
         #1 chk("rr_ready", bus.req_ready, 3'b001 << (c % 3));
      end
      @(negedge clk);
      drive('0);

      // Requester 0 streaming addresses 0..4 with no gaps
      do_reset();
      for (int c = 0; c < 9; c++) begin
         @(negedge clk);
         if (c >= 1 && c <= 5) chk("stream_rom_addr", bus.rom_addr, c - 1);
         if (c >= 3 && c <= 7) begin
            chk("stream_rsp_valid", bus.rsp_valid, 3'b001);
            chk("stream_rsp_data", bus.rsp_data[0], rom_bit(AW'(c - 3)));
         end
         if (c == 8) chk("stream_end", bus.rsp_valid, 0);
         a_cur[0] = AW'(c);
         drive((c < 5) ? 3'b001 : 3'b000);
      end

      // Randomized run against the reference model
      do_reset();
      pend.delete();
      m_ptr = 0; cyc = 0; m_rom = '0; m_rv = '0; m_rd = '0; m_err = 1'b0;
      last_ready = '0;
      v = '0;
      for (int it = 0; it < 400; it++) begin
         @(negedge clk);
         chk("rnd_rom_addr", bus.rom_addr, m_rom);
         chk("rnd_rsp_valid", bus.rsp_valid, m_rv);
         chk("rnd_rsp_data", bus.rsp_data, m_rd);
         chk("rnd_err_oob", bus.err_oob, m_err);
         for (int i = 0; i < N; i++) begin
            if (v[i] && !last_ready[i]) begin
               if ($urandom_range(0, 3) == 0) a_cur[i] = rnd_addr();
            end else begin
               v[i] = 1'($urandom_range(0, 1));
               a_cur[i] = rnd_addr();
            end
         end
         drive(v);
         #1;
         g = pick(v, m_ptr);
         exp_ready = (g < 0) ? '0 : N'(1 << g);
         chk("rnd_ready", bus.req_ready, exp_ready);
         last_ready = exp_ready;

         cyc++;
         m_rv = '0;
         if (pend.size() > 0 && pend[0].due == cyc) begin
            m_rv[pend[0].g] = 1'b1;
            m_rd[pend[0].g] = pend[0].b;
            void'(pend.pop_front());
         end
         if (g >= 0) begin
            oob = (int'(a_cur[g]) >= DEPTH);
            m_rom = oob ? '0 : a_cur[g];
            if (oob) m_err = 1'b1;
            pend.push_back('{cyc + 2, g, oob ? 1'b0 : rom_bit(a_cur[g])});
            m_ptr = (g + 1) % N;
         end
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
